multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath, directly upstream of the unified instruction/data memory.
- Sequences fetch/decode/execute/memory/writeback per instruction.
- Drives memory strobes (memread, IorD, we) plus IR, register file, ALU-mux and PC enables.
- Outputs are Moore: decoded from the state register only, except pcwrite_cond gating.

Parameters:
- INSTR_CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- op  input  6  opcode field from the instruction register, instr[31:26].
- zero  input  1  ALU zero flag.
- memread  output  1  memory read enable.
- IorD  output  1  memory address select: 0 = pc_address, 1 = alu_address.
- we  output  1  memory write enable.
- irwrite  output  1  instruction register load.
- regdst  output  1  register-file destination select: 1 = rd, 0 = rt.
- memtoreg  output  1  register-file write-data select: 1 = MDR.
- regwrite  output  1  register-file write enable.
- alusrca  output  1  ALU operand A select: 0 = PC, 1 = rs.
- alusrcb  output  2  ALU operand B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- aluop  output  2  ALU op class: 00 = add, 01 = sub, 10 = funct.
- pcsrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen  output  1  PC load = pcwrite | (branch & zero).
- instr_count  output  INSTR_CNT_W  count of retired instructions.
- state_dbg  output  4  current state encoding.

Behaviour:
- While rst == 0 at a rising edge: state <= FETCH, instr_count <= 0.
- While rst == 0, all control outputs are forced to 0 combinationally; state_dbg reads FETCH.
- Reset asserted mid-instruction abandons the instruction with no further writes; instr_count does not increment.
- States (4-bit encoding): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, TRAP=12.
- FETCH:
  - Outputs: memread=1, IorD=0, irwrite=1, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, pcwrite=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - Next state by op: 100011/101011 -> MEMADR; 000000 -> RTEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other -> undefined-opcode path (see Optional Feature).
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if op == lw, MEMWR if op == sw.
- MEMRD: memread=1, IorD=1. Next: MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR: we=1, IorD=1. Next: FETCH.
- RTEX: alusrca=1, alusrcb=00, aluop=10. Next: RTWB.
- RTWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
- JEX: pcwrite=1, pcsrc=10. Next: FETCH.
- Outputs not listed for a state are 0.
- memread and we are never both 1 in any state.
- Latencies (cycles, FETCH to FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- instr_count increments by 1 on every transition into FETCH from a non-reset state; wraps modulo 2^INSTR_CNT_W silently.
- op is sampled every cycle. The datapath holds the IR stable outside FETCH, so no internal op latch is required.

Optional Feature:
- Macro: MC_ILLEGAL_OP_TRAP_EN.
- Defined:
  - Undefined opcode in DECODE -> TRAP.
  - TRAP holds all outputs 0, stays in TRAP until reset, and asserts extra output port illegal_op = 1.
  - instr_count does not increment for the trapping instruction.
- Undefined:
  - Undefined opcode in DECODE -> FETCH (executes as NOP, 2 cycles); instr_count increments.
  - No illegal_op port and no TRAP state.

Decomposition:
- Package mc_pkg:
  - state enum/localparams.
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - ALUSRCB_* and PCSRC_* encodings.
  - ALUOP_* encodings.
- One sub-module: mc_outdec, a purely combinational state -> control-vector decoder.
- The top level keeps the state register, next-state logic, counter and pcen gating.

Test Plan:
- rst=0 for 3 cycles, then 1 -> during reset all outputs 0 and instr_count=0; first cycle after release: state_dbg=0, memread=1, irwrite=1, pcen=1.
- op=100011 (lw) -> state sequence 0,1,2,3,4,0; IorD=1 only in state 3; regwrite=1 with memtoreg=1 in state 4; instr_count=1.
- op=101011 (sw) -> sequence 0,1,2,5,0; we=1 only in state 5 with IorD=1; regwrite never 1.
- op=000100, zero=1 then repeat with zero=0 -> pcen=1 in BEQEX for the first run, pcen=0 for the second; both runs 3 cycles.
- Sequence R-type, addi, j -> cycle counts 4, 4, 3; instr_count=3; regdst=1 in RTWB, regdst=0 in ADDIWB.
- op=111111 -> with MC_ILLEGAL_OP_TRAP_EN: state_dbg=12 stays there and illegal_op=1; without it: back to FETCH after 2 cycles and instr_count+1. Reset during TRAP returns to FETCH.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// mc_pkg: state encoding, opcodes, mux encodings and control vector for multicycle_control.
// MC_ILLEGAL_OP_TRAP_EN adds the TRAP state.
package mc_pkg;
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQEX  = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JEX    = 4'd11
`ifdef MC_ILLEGAL_OP_TRAP_EN
      , S_TRAP = 4'd12
`endif
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUSRCB_RT    = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       memread;
      logic       iord;
      logic       we;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
   } ctrl_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller <-> datapath/memory control bundle.
// illegal_op exists only with MC_ILLEGAL_OP_TRAP_EN.
interface multicycle_control_if #(parameter int INSTR_CNT_W = 32);
   logic [5:0]             op;
   logic                   zero;
   logic                   memread;
   logic                   IorD;
   logic                   we;
   logic                   irwrite;
   logic                   regdst;
   logic                   memtoreg;
   logic                   regwrite;
   logic                   alusrca;
   logic [1:0]             alusrcb;
   logic [1:0]             aluop;
   logic [1:0]             pcsrc;
   logic                   pcen;
   logic [INSTR_CNT_W-1:0] instr_count;
   logic [3:0]             state_dbg;
`ifdef MC_ILLEGAL_OP_TRAP_EN
   logic                   illegal_op;
`endif

   modport master (
      input  op, zero,
      output memread, IorD, we, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, aluop, pcsrc, pcen, instr_count, state_dbg
`ifdef MC_ILLEGAL_OP_TRAP_EN
      , output illegal_op
`endif
   );

   modport slave (
      output op, zero,
      input  memread, IorD, we, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, aluop, pcsrc, pcen, instr_count, state_dbg
`ifdef MC_ILLEGAL_OP_TRAP_EN
      , input illegal_op
`endif
   );
endinterface

// File: rtl/multicycle_control_outdec.sv
// mc_outdec: combinational Moore decode of the FSM state into the control vector.
module mc_outdec
   import mc_pkg::*;
(
   input  state_e state_i,
   output ctrl_t  ctrl_o
);
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.memread = 1'b1;
            ctrl_o.irwrite = 1'b1;
            ctrl_o.alusrcb = ALUSRCB_FOUR;
            ctrl_o.aluop   = ALUOP_ADD;
            ctrl_o.pcsrc   = PCSRC_ALU;
            ctrl_o.pcwrite = 1'b1;
         end
         S_DECODE: ctrl_o.alusrcb = ALUSRCB_IMMSH;
         S_MEMADR, S_ADDIEX: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = ALUSRCB_IMM;
         end
         S_MEMRD: begin
            ctrl_o.memread = 1'b1;
            ctrl_o.iord    = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.memtoreg = 1'b1;
            ctrl_o.regwrite = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.we   = 1'b1;
            ctrl_o.iord = 1'b1;
         end
         S_RTEX: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = ALUSRCB_RT;
            ctrl_o.aluop   = ALUOP_FUNCT;
         end
         S_RTWB: begin
            ctrl_o.regdst   = 1'b1;
            ctrl_o.regwrite = 1'b1;
         end
         S_BEQEX: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.aluop   = ALUOP_SUB;
            ctrl_o.branch  = 1'b1;
            ctrl_o.pcsrc   = PCSRC_ALUOUT;
         end
         S_ADDIWB: ctrl_o.regwrite = 1'b1;
         S_JEX: begin
            ctrl_o.pcwrite = 1'b1;
            ctrl_o.pcsrc   = PCSRC_JUMP;
         end
         default: ctrl_o = '0;
      endcase
   end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS main control FSM with retired-instruction counter.
// MC_ILLEGAL_OP_TRAP_EN: undefined opcodes lock the FSM in TRAP and raise illegal_op.
module multicycle_control
   import mc_pkg::*;
#(
   parameter int INSTR_CNT_W = 32
) (
   input logic                  clk,
   input logic                  rst,
   multicycle_control_if.master bus
);
   state_e                 state_q, state_d;
   logic [INSTR_CNT_W-1:0] cnt_q;
   ctrl_t                  ctrl, ctrl_g;

   mc_outdec u_outdec (.state_i(state_q), .ctrl_o(ctrl));

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
`ifdef MC_ILLEGAL_OP_TRAP_EN
               default:      state_d = S_TRAP;
`else
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_RTEX:   state_d = S_RTWB;
         S_ADDIEX: state_d = S_ADDIWB;
`ifdef MC_ILLEGAL_OP_TRAP_EN
         S_TRAP:   state_d = S_TRAP;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   // Every re-entry into FETCH retires exactly one instruction.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == S_FETCH) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign ctrl_g          = rst ? ctrl : '0;
   assign bus.memread     = ctrl_g.memread;
   assign bus.IorD        = ctrl_g.iord;
   assign bus.we          = ctrl_g.we;
   assign bus.irwrite     = ctrl_g.irwrite;
   assign bus.regdst      = ctrl_g.regdst;
   assign bus.memtoreg    = ctrl_g.memtoreg;
   assign bus.regwrite    = ctrl_g.regwrite;
   assign bus.alusrca     = ctrl_g.alusrca;
   assign bus.alusrcb     = ctrl_g.alusrcb;
   assign bus.aluop       = ctrl_g.aluop;
   assign bus.pcsrc       = ctrl_g.pcsrc;
   assign bus.pcen        = ctrl_g.pcwrite | (ctrl_g.branch & bus.zero);
   assign bus.instr_count = cnt_q;
   assign bus.state_dbg   = rst ? state_q : S_FETCH;
`ifdef MC_ILLEGAL_OP_TRAP_EN
   assign bus.illegal_op  = rst & (state_q == S_TRAP);
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle expectations queued by the driver, checked by a negedge monitor.
module tb_multicycle_control;
   typedef struct {
      string       nm;
      logic [19:0] v;
      logic [31:0] c;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst;
   exp_t   q[$];
   int     checks = 0;
   int     errors = 0;
   logic [31:0] cnt = 0;

   multicycle_control_if #(.INSTR_CNT_W(32)) bus ();
   multicycle_control #(.INSTR_CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // {memread,IorD,we,irwrite, regdst,memtoreg,regwrite,alusrca, alusrcb, aluop, pcsrc, pcen, illegal_op}
   function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic z);
      case (s)
         4'd0:    return 16'b1001_0000_01_00_00_1_0;
         4'd1:    return 16'b0000_0000_11_00_00_0_0;
         4'd2:    return 16'b0000_0001_10_00_00_0_0;
         4'd3:    return 16'b1100_0000_00_00_00_0_0;
         4'd4:    return 16'b0000_0110_00_00_00_0_0;
         4'd5:    return 16'b0110_0000_00_00_00_0_0;
         4'd6:    return 16'b0000_0001_00_10_00_0_0;
         4'd7:    return 16'b0000_1010_00_00_00_0_0;
         4'd8:    return {14'b0000_0001_00_01_01, z, 1'b0};
         4'd9:    return 16'b0000_0001_10_00_00_0_0;
         4'd10:   return 16'b0000_0010_00_00_00_0_0;
         4'd11:   return 16'b0000_0000_00_00_10_1_0;
         4'd12:   return 16'b0000_0000_00_00_00_0_1;
         default: return 16'hxxxx;
      endcase
   endfunction

   task automatic push(input string nm, input logic [19:0] v, input logic [31:0] c);
      exp_t e;
      e.nm = nm;
      e.v  = v;
      e.c  = c;
      q.push_back(e);
   endtask

   task automatic run(input string nm, input logic [5:0] o, input logic z, input int n,
                      input logic [31:0] seq, input bit retire);
      bus.op   = o;
      bus.zero = z;
      for (int i = 0; i < n; i++)
         push($sformatf("%s[%0d]", nm, i), {seq[4*i +: 4], exp_ctrl(seq[4*i +: 4], z)}, cnt);
      repeat (n) @(posedge clk);
      #1;
      if (retire) cnt = cnt + 1;
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cnt = 0;
      push(nm, 20'h0, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin : monitor
      exp_t        e;
      logic        ill;
      logic [19:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
`ifdef MC_ILLEGAL_OP_TRAP_EN
            ill = bus.illegal_op;
`else
            ill = 1'b0;
`endif
            act = {bus.state_dbg, bus.memread, bus.IorD, bus.we, bus.irwrite, bus.regdst,
                   bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop,
                   bus.pcsrc, bus.pcen, ill};
            checks++;
            if (act !== e.v || bus.instr_count !== e.c) begin
               errors++;
               $display("FAIL %s: got vec=%h cnt=%0d, expected vec=%h cnt=%0d",
                        e.nm, act, bus.instr_count, e.v, e.c);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      rst      = 1'b0;
      bus.op   = 6'b000000;
      bus.zero = 1'b0;
      push("reset0", 20'h0, 32'd0);
      push("reset1", 20'h0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      run("lw",     6'b100011, 1'b0, 5, 32'h0004_3210, 1'b1);
      run("sw",     6'b101011, 1'b0, 4, 32'h0000_5210, 1'b1);
      run("beq_z1", 6'b000100, 1'b1, 3, 32'h0000_0810, 1'b1);
      run("beq_z0", 6'b000100, 1'b0, 3, 32'h0000_0810, 1'b1);
      run("rtype",  6'b000000, 1'b0, 4, 32'h0000_7610, 1'b1);
      run("addi",   6'b001000, 1'b1, 4, 32'h0000_A910, 1'b1);
      run("j",      6'b000010, 1'b0, 3, 32'h0000_0B10, 1'b1);
      run("lw_cut", 6'b100011, 1'b0, 3, 32'h0000_0210, 1'b0);
      do_reset("reset_mid");
      run("j_after_rst", 6'b000010, 1'b0, 3, 32'h0000_0B10, 1'b1);
`ifdef MC_ILLEGAL_OP_TRAP_EN
      run("trap", 6'b111111, 1'b0, 5, 32'h000C_CC10, 1'b0);
      do_reset("reset_trap");
`else
      run("nop", 6'b111111, 1'b0, 2, 32'h0000_0010, 1'b1);
`endif
      run("j_final", 6'b000010, 1'b0, 3, 32'h0000_0B10, 1'b1);
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
